// File: rtl/if_id_fetch_buf.sv
// if_id_fetch_buf: DEPTH-entry FIFO carrying {pc, inst} from fetch to decode.
// Valid/ready on both sides, flush for branch redirect, occupancy count.
// Optional feature: define IF_ID_BYPASS_EN for a 0-cycle path when the buffer is
// empty. Without it, a pushed instruction is visible at id_* one cycle later.
module if_id_fetch_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       flush_in,
  input  logic                       if_valid_in,
  input  logic [ADDR_W-1:0]          if_pc_in,
  input  logic [DATA_W-1:0]          if_inst_in,
  output logic                       if_ready_out,
  output logic                       id_valid_out,
  output logic [ADDR_W-1:0]          id_pc_out,
  output logic [DATA_W-1:0]          id_inst_out,
  input  logic                       id_ready_in,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count, cnt_nxt;

  logic   empty, full, head_vld, byp;
  logic   push, pop, wr_en, rd_en;
  entry_t in_ent, out_ent;

  assign in_ent   = '{pc: if_pc_in, inst: if_inst_in};
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  // Ready is a pure function of occupancy so decode stalls never reach fetch combinationally.
  assign if_ready_out = !full;
  assign head_vld = !empty && !flush_in;

`ifdef IF_ID_BYPASS_EN
  // Empty buffer: the incoming instruction is shown to decode in the same cycle.
  assign byp = empty && if_valid_in && !flush_in;
`else
  assign byp = 1'b0;
`endif

  assign push = if_valid_in && if_ready_out && !flush_in;
  assign pop  = id_valid_out && id_ready_in;
  // A bypassed instruction that decode takes immediately never touches storage,
  // and a bypass pop consumes the input rather than the (empty) head.
  assign wr_en = push && !(byp && id_ready_in);
  assign rd_en = pop && !byp;

  // Output mux: bypass input, stored head, or a zero bubble.
  always_comb begin
    out_ent      = '0;
    id_valid_out = 1'b0;
    if (byp) begin
      out_ent      = in_ent;
      id_valid_out = 1'b1;
    end else if (head_vld) begin
      out_ent      = mem[rd_ptr];
      id_valid_out = 1'b1;
    end
  end

  assign id_pc_out   = out_ent.pc;
  assign id_inst_out = out_ent.inst;
  assign count_out   = count;

  // Next occupancy: a simultaneous write and read cancel out.
  always_comb begin
    cnt_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   cnt_nxt = count + CNT_W'(1);
      2'b01:   cnt_nxt = count - CNT_W'(1);
      default: cnt_nxt = count;
    endcase
  end

  // Storage is data-only; it needs no reset since count gates visibility.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr] <= in_ent;
  end

  // Pointer/count state; flush rewinds everything to the empty origin.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= cnt_nxt;
    end
  end

  // Occupancy must never exceed capacity.
  a_cnt_bound: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_if_id_fetch_buf.sv
// Bench for if_id_fetch_buf: a DEPTH=2 instance and a DEPTH=4 instance.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_if_id_fetch_buf;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DEPTH=2 instance
  logic        a_flush, a_vld, a_rdy, a_if_rdy, a_id_vld;
  logic [31:0] a_pc, a_inst, a_id_pc, a_id_inst;
  logic [1:0]  a_cnt;
  // DEPTH=4 instance
  logic        b_flush, b_vld, b_rdy, b_if_rdy, b_id_vld;
  logic [31:0] b_pc, b_inst, b_id_pc, b_id_inst;
  logic [2:0]  b_cnt;

  if_id_fetch_buf #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) u_d2 (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(a_flush),
    .if_valid_in(a_vld), .if_pc_in(a_pc), .if_inst_in(a_inst),
    .if_ready_out(a_if_rdy), .id_valid_out(a_id_vld), .id_pc_out(a_id_pc),
    .id_inst_out(a_id_inst), .id_ready_in(a_rdy), .count_out(a_cnt));

  if_id_fetch_buf #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) u_d4 (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(b_flush),
    .if_valid_in(b_vld), .if_pc_in(b_pc), .if_inst_in(b_inst),
    .if_ready_out(b_if_rdy), .id_valid_out(b_id_vld), .id_pc_out(b_id_pc),
    .id_inst_out(b_id_inst), .id_ready_in(b_rdy), .count_out(b_cnt));

  int vectors = 0;
  int errors  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {a_flush, a_vld, a_rdy, a_pc, a_inst} = '0;
    {b_flush, b_vld, b_rdy, b_pc, b_inst} = '0;
    #3;
    vectors++;
    if ({a_id_vld, a_id_pc, a_id_inst, a_cnt, a_if_rdy} !== {1'b0, 32'h0, 32'h0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_d2: got vld=%b pc=%h inst=%h cnt=%0d rdy=%b, want 0/0/0/0/1",
               a_id_vld, a_id_pc, a_id_inst, a_cnt, a_if_rdy);
    end
    vectors++;
    if ({b_id_vld, b_cnt, b_if_rdy} !== {1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_d4: got vld=%b cnt=%0d rdy=%b, want 0/0/1", b_id_vld, b_cnt, b_if_rdy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({a_id_vld, a_cnt, b_id_vld, b_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_release: got a_vld=%b a_cnt=%0d b_vld=%b b_cnt=%0d, want all 0",
               a_id_vld, a_cnt, b_id_vld, b_cnt);
    end
    tick();
  endtask

  task automatic test_single();
    a_vld = 1'b1; a_pc = 32'h100; a_inst = 32'h0000_0013; a_rdy = 1'b1;
    @(negedge clk);
`ifdef IF_ID_BYPASS_EN
    vectors++;
    if ({a_id_vld, a_id_pc, a_id_inst, a_cnt} !== {1'b1, 32'h100, 32'h13, 2'd0}) begin
      errors++;
      $display("FAIL single_bypass: got vld=%b pc=%h inst=%h cnt=%0d, want 1/100/13/0",
               a_id_vld, a_id_pc, a_id_inst, a_cnt);
    end
    tick();
    a_vld = 1'b0;
    @(negedge clk);
    vectors++;
    if ({a_id_vld, a_cnt} !== {1'b0, 2'd0}) begin
      errors++;
      $display("FAIL single_consumed: got vld=%b cnt=%0d, want 0/0", a_id_vld, a_cnt);
    end
`else
    vectors++;
    if ({a_id_vld, a_cnt, a_if_rdy} !== {1'b0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL single_push_cycle: got vld=%b cnt=%0d rdy=%b, want 0/0/1", a_id_vld, a_cnt, a_if_rdy);
    end
    tick();
    a_vld = 1'b0;
    @(negedge clk);
    vectors++;
    if ({a_id_vld, a_id_pc, a_id_inst, a_cnt} !== {1'b1, 32'h100, 32'h13, 2'd1}) begin
      errors++;
      $display("FAIL single_next_cycle: got vld=%b pc=%h inst=%h cnt=%0d, want 1/100/13/1",
               a_id_vld, a_id_pc, a_id_inst, a_cnt);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({a_id_vld, a_id_pc, a_id_inst, a_cnt} !== {1'b0, 32'h0, 32'h0, 2'd0}) begin
      errors++;
      $display("FAIL single_drained: got vld=%b pc=%h inst=%h cnt=%0d, want 0/0/0/0",
               a_id_vld, a_id_pc, a_id_inst, a_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_back_pressure();
    int got;
    bit sent;
    exp_q.delete();
    a_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_vld = 1'b1; a_pc = 32'h100 + 32'(4 * i); a_inst = 32'hA000_0000 + a_pc;
      @(negedge clk);
      if (i < 2) exp_q.push_back({a_pc, a_inst});
      if (i == 2) begin
        vectors++;
        if ({a_cnt, a_if_rdy} !== {2'd2, 1'b0}) begin
          errors++;
          $display("FAIL full_hold: got cnt=%0d rdy=%b, want 2/0", a_cnt, a_if_rdy);
        end
      end
      tick();
    end
    // pc 0x108 is still held; release decode
    a_rdy = 1'b1; got = 0; sent = 1'b0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      a_vld = !sent;
      @(negedge clk);
      if (a_vld && a_if_rdy) begin exp_q.push_back({a_pc, a_inst}); sent = 1'b1; end
      if (a_id_vld && a_rdy) begin
        exp_e = exp_q.pop_front();
        got++;
        vectors++;
        if ({a_id_pc, a_id_inst} !== exp_e) begin
          errors++;
          $display("FAIL order_d2: got pc=%h inst=%h, want pc=%h inst=%h",
                   a_id_pc, a_id_inst, exp_e[63:32], exp_e[31:0]);
        end
      end
      tick();
    end
    vectors++;
    if (got != 3) begin
      errors++;
      $display("FAIL order_d2_count: got %0d pops, want 3", got);
    end
    a_vld = 1'b0; a_rdy = 1'b0;
  endtask

  task automatic test_full_pop();
    int got;
    exp_q.delete();
    a_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_vld = 1'b1; a_pc = 32'h300 + 32'(4 * i); a_inst = 32'hB000_0000 + a_pc;
      exp_q.push_back({a_pc, a_inst});
      tick();
    end
    a_vld = 1'b1; a_pc = 32'h308; a_inst = 32'hB000_0308; a_rdy = 1'b1;
    @(negedge clk);
    vectors++;
    if ({a_cnt, a_if_rdy, a_id_vld, a_id_pc} !== {2'd2, 1'b0, 1'b1, 32'h300}) begin
      errors++;
      $display("FAIL full_pop: got cnt=%0d rdy=%b vld=%b pc=%h, want 2/0/1/300",
               a_cnt, a_if_rdy, a_id_vld, a_id_pc);
    end
    void'(exp_q.pop_front());
    tick();
    a_rdy = 1'b0;
    @(negedge clk);
    vectors++;
    if ({a_cnt, a_if_rdy} !== {2'd1, 1'b1}) begin
      errors++;
      $display("FAIL slot_freed: got cnt=%0d rdy=%b, want 1/1", a_cnt, a_if_rdy);
    end
    exp_q.push_back({a_pc, a_inst});
    tick();
    a_vld = 1'b0;
    @(negedge clk);
    vectors++;
    if (a_cnt !== 2'd2) begin
      errors++;
      $display("FAIL refilled: got cnt=%0d, want 2", a_cnt);
    end
    tick();
    a_rdy = 1'b1; got = 0;
    for (int c = 0; c < 8 && got < 2; c++) begin
      @(negedge clk);
      if (a_id_vld) begin
        exp_e = exp_q.pop_front();
        got++;
        vectors++;
        if ({a_id_pc, a_id_inst} !== exp_e) begin
          errors++;
          $display("FAIL drain_d2: got pc=%h inst=%h, want pc=%h inst=%h",
                   a_id_pc, a_id_inst, exp_e[63:32], exp_e[31:0]);
        end
      end
      tick();
    end
    vectors++;
    if (got != 2) begin
      errors++;
      $display("FAIL drain_d2_count: got %0d pops, want 2", got);
    end
    a_rdy = 1'b0;
  endtask

  task automatic test_flush();
    a_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_vld = 1'b1; a_pc = 32'h400 + 32'(4 * i); a_inst = 32'hC000_0000 + a_pc;
      tick();
    end
    a_flush = 1'b1; a_vld = 1'b1; a_pc = 32'h200; a_inst = 32'hDEAD_0200; a_rdy = 1'b1;
    @(negedge clk);
    vectors++;
    if ({a_id_vld, a_id_pc, a_id_inst, a_cnt} !== {1'b0, 32'h0, 32'h0, 2'd2}) begin
      errors++;
      $display("FAIL flush_same_cycle: got vld=%b pc=%h inst=%h cnt=%0d, want 0/0/0/2",
               a_id_vld, a_id_pc, a_id_inst, a_cnt);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({a_id_vld, a_cnt} !== {1'b0, 2'd0}) begin
      errors++;
      $display("FAIL flush_held: got vld=%b cnt=%0d, want 0/0", a_id_vld, a_cnt);
    end
    tick();
    a_flush = 1'b0; a_vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({a_id_vld, a_id_pc, a_id_inst, a_cnt} !== {1'b0, 32'h0, 32'h0, 2'd0}) begin
        errors++;
        $display("FAIL flush_after: got vld=%b pc=%h inst=%h cnt=%0d, want 0/0/0/0",
                 a_id_vld, a_id_pc, a_id_inst, a_cnt);
      end
      tick();
    end
    a_rdy = 1'b0;
  endtask

  task automatic test_wrap();
    int sent, got;
    exp_q.delete();
    sent = 0; got = 0;
    for (int c = 0; c < 300 && got < 10; c++) begin
      b_vld = (sent < 10) && ($urandom_range(0, 3) != 0);
      b_pc = 32'(4 * sent); b_inst = 32'h5000_0000 ^ b_pc;
      b_rdy = $urandom_range(0, 1) == 1;
      @(negedge clk);
      vectors++;
      if (b_cnt > 3'd4) begin
        errors++;
        $display("FAIL wrap_cnt_bound: got cnt=%0d, want <=4", b_cnt);
      end
      if (b_vld && b_if_rdy) begin exp_q.push_back({b_pc, b_inst}); sent++; end
      if (b_id_vld && b_rdy) begin
        exp_e = exp_q.pop_front();
        got++;
        vectors++;
        if ({b_id_pc, b_id_inst} !== exp_e) begin
          errors++;
          $display("FAIL wrap_order: got pc=%h inst=%h, want pc=%h inst=%h",
                   b_id_pc, b_id_inst, exp_e[63:32], exp_e[31:0]);
        end
      end
      tick();
    end
    vectors++;
    if (got != 10) begin
      errors++;
      $display("FAIL wrap_count: got %0d pops, want 10", got);
    end
    b_vld = 1'b0; b_rdy = 1'b0;
  endtask

  task automatic test_async_reset();
    b_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_vld = 1'b1; b_pc = 32'h600 + 32'(4 * i); b_inst = 32'hE000_0000 + b_pc;
      tick();
    end
    b_vld = 1'b0;
    @(negedge clk);
    vectors++;
    if (b_cnt !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset_cnt: got cnt=%0d, want 3", b_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({b_id_vld, b_id_pc, b_id_inst, b_cnt, b_if_rdy} !== {1'b0, 32'h0, 32'h0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got vld=%b pc=%h inst=%h cnt=%0d rdy=%b, want 0/0/0/0/1",
               b_id_vld, b_id_pc, b_id_inst, b_cnt, b_if_rdy);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({b_id_vld, b_cnt} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL post_reset: got vld=%b cnt=%0d, want 0/0", b_id_vld, b_cnt);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_pressure();
    test_full_pop();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, want $finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
